// File: rtl/lsu_pkg.sv
// Shared execute-stage constants: ALU opcodes, load/store funct3 codes
// and the access-size helper used by the load/store unit.
package lsu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_e;

    // The low two funct3 bits encode the access width for loads and stores.
    function automatic acc_size_e acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return ACC_BYTE;
            2'b01:   return ACC_HALF;
            default: return ACC_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Single-outstanding data-memory bus between the LSU (master) and memory (slave).
interface lsu_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: classifies an access, builds store
// strobes/replicated data and extracts/extends the loaded lane.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic        rawMisaligned;

    // Legality depends on direction; alignment on width, and illegal wins.
    always_comb begin
        illegal       = 1'b0;
        rawMisaligned = 1'b0;
        if (is_store) begin
            illegal = !(funct3 == FUNCT3_SB || funct3 == FUNCT3_SH || funct3 == FUNCT3_SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (acc_size(funct3))
            ACC_HALF: rawMisaligned = addr_lo[0];
            ACC_WORD: rawMisaligned = (addr_lo != 2'b00);
            default:  rawMisaligned = 1'b0;
        endcase
        misaligned = rawMisaligned && !illegal;
    end

    // Store lanes: strobes shifted to the addressed byte, data replicated.
    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (is_store) begin
            case (funct3)
                FUNCT3_SB: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                FUNCT3_SH: begin
                    wstrb = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                FUNCT3_SW: begin
                    wstrb = 4'b1111;
                    wdata = store_data;
                end
                default: begin
                    wstrb = 4'b0000;
                    wdata = 32'h0;
                end
            endcase
        end
    end

    // Load lanes: pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        byteLane  = mem_rdata[{addr_lo, 3'b000} +: 8];
        halfLane  = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = 32'h0;
        if (!is_store) begin
            case (funct3)
                FUNCT3_LB:  load_data = {{24{byteLane[7]}}, byteLane};
                FUNCT3_LH:  load_data = {{16{halfLane[15]}}, halfLane};
                FUNCT3_LW:  load_data = mem_rdata;
                FUNCT3_LBU: load_data = {24'h0, byteLane};
                FUNCT3_LHU: load_data = {16'h0, halfLane};
                default:    load_data = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from execute, issues it on the
// data-memory bus with an ack timeout, and reports the result for one cycle.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_err,
    lsu_if.master       mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;
    logic        berr_q, berr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        selIsStore;
    logic [2:0]  selFunct3;
    logic [1:0]  selAddrLo;
    logic [3:0]  aWstrb;
    logic [31:0] aWdata;
    logic [31:0] aLoad;
    logic        aMis;
    logic        aIll;

    // In IDLE the aligner classifies the incoming request; afterwards it
    // works on the latched copy so the ack-cycle lane extraction is stable.
    always_comb begin
        selIsStore = is_store_q;
        selFunct3  = funct3_q;
        selAddrLo  = addr_lo_q;
        if (state_q == S_IDLE) begin
            selIsStore = is_store;
            selFunct3  = funct3;
            selAddrLo  = addr[1:0];
        end
    end

    lsu_align u_align (
        .is_store   (selIsStore),
        .funct3     (selFunct3),
        .addr_lo    (selAddrLo),
        .store_data (store_data),
        .mem_rdata  (mem.mem_rdata),
        .wstrb      (aWstrb),
        .wdata      (aWdata),
        .load_data  (aLoad),
        .misaligned (aMis),
        .illegal    (aIll)
    );

    // Next-state and datapath updates; everything holds unless changed.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        req_d      = req_q;
        we_d       = we_q;
        maddr_d    = maddr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        ld_d       = ld_q;
        mis_d      = mis_q;
        ill_d      = ill_q;
        berr_d     = berr_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_lo_d  = addr[1:0];
                    if (aIll || aMis) begin
                        ill_d   = aIll;
                        mis_d   = aMis;
                        state_d = S_RESP;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store;
                        maddr_d = {addr[31:2], 2'b00};
                        wstrb_d = aWstrb;
                        wdata_d = aWdata;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ack || cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    maddr_d = 32'h0;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'h0;
                    state_d = S_RESP;
                    if (mem.mem_ack) begin
                        ld_d = aLoad;
                    end else begin
                        berr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                ld_d    = 32'h0;
                mis_d   = 1'b0;
                ill_d   = 1'b0;
                berr_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'h0;
            ld_q       <= 32'h0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
            berr_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            ld_q       <= ld_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
            berr_q     <= berr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_RESP);
    assign load_data      = ld_q;
    assign misaligned     = mis_q;
    assign illegal        = ill_q;
    assign bus_err        = berr_q;
    assign mem.mem_req    = req_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = maddr_q;
    assign mem.mem_wstrb  = wstrb_q;
    assign mem.mem_wdata  = wdata_q;

endmodule
